// File: rtl/dmem_req_if.sv
// ---------------------------------------------------------------------------
// dmem_req_if
// Bundles the execution-unit command handshake and the dmem request bus used
// by dmem_req_ctrl.
//
//   Command side : cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i  (to ctrl)
//                  cmd_ready_o, done_o, rdata_o                       (from ctrl)
//   dmem side    : read_write_req_o, write_en_o, addr_o, din_o        (from ctrl)
//                  dout_i, refused_i                                  (to ctrl)
//   error_o      : sticky retry-timeout flag, present only when
//                  DMEM_RETRY_TIMEOUT_EN is defined.
//
// Modports: slave  = controller view, master = execution unit / dmem view.
// ---------------------------------------------------------------------------
interface dmem_req_if #(
  parameter int D_WIDTH = 16,
  parameter int A_WIDTH = 8
);
  logic               cmd_valid_i;
  logic               cmd_write_i;
  logic [A_WIDTH-1:0] cmd_addr_i;
  logic [D_WIDTH-1:0] cmd_wdata_i;
  logic               cmd_ready_o;
  logic               done_o;
  logic [D_WIDTH-1:0] rdata_o;
  logic               read_write_req_o;
  logic               write_en_o;
  logic [A_WIDTH-1:0] addr_o;
  logic [D_WIDTH-1:0] din_o;
  logic [D_WIDTH-1:0] dout_i;
  logic               refused_i;
`ifdef DMEM_RETRY_TIMEOUT_EN
  logic               error_o;
`endif

  modport slave (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, dout_i, refused_i,
`ifdef DMEM_RETRY_TIMEOUT_EN
    output error_o,
`endif
    output cmd_ready_o, done_o, rdata_o, read_write_req_o, write_en_o, addr_o, din_o
  );

  modport master (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, dout_i, refused_i,
`ifdef DMEM_RETRY_TIMEOUT_EN
    input  error_o,
`endif
    input  cmd_ready_o, done_o, rdata_o, read_write_req_o, write_en_o, addr_o, din_o
  );
endinterface

// File: rtl/dmem_req_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_req_ctrl
// Accepts one load/store command at a time from the execution unit, presents
// it to dmem until dmem stops refusing it, and reports completion with a
// one-cycle done_o pulse. Load data is captured one cycle after the request
// is accepted and held on rdata_o until the next completed load.
//
// Ports:
//   clk      : single clock, rising edge
//   reset_i  : synchronous active-high reset
//   bus      : dmem_req_if.slave (command handshake + dmem request bus)
//
// Optional feature (macro DMEM_RETRY_TIMEOUT_EN): after MAX_RETRY consecutive
// refusals the command is abandoned through an ERROR state, done_o pulses and
// the sticky error_o flag is raised until reset. Without the macro the
// controller retries indefinitely and error_o does not exist.
// ---------------------------------------------------------------------------
module dmem_req_ctrl #(
  parameter int D_WIDTH   = 16,
  parameter int A_WIDTH   = 8,
  parameter int MAX_RETRY = 4
) (
  input  logic        clk,
  input  logic        reset_i,
  dmem_req_if.slave   bus
);

  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
`ifdef DMEM_RETRY_TIMEOUT_EN
    ERROR     = 2'd3,
`endif
    WAIT_DATA = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic               cmd_ready;
  logic               accept;
  logic               capture;
  logic               done_nxt;
  logic               retry_inc;

  logic               lat_write;
  logic [A_WIDTH-1:0] addr_q;
  logic [D_WIDTH-1:0] din_q;
  logic [D_WIDTH-1:0] rdata_q;
  logic               done_q;
  logic [RETRY_W-1:0] retry_cnt;

`ifdef DMEM_RETRY_TIMEOUT_EN
  localparam logic [RETRY_W-1:0] LAST_TRY = RETRY_W'(MAX_RETRY - 1);
  logic               set_err;
  logic               err_q;
`endif

  // Ready is gated by reset so nothing can be accepted on a reset edge.
  assign cmd_ready = (state == IDLE) && !reset_i;

  always_ff @(posedge clk) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    done_nxt  = 1'b0;
    retry_inc = 1'b0;
`ifdef DMEM_RETRY_TIMEOUT_EN
    set_err   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.cmd_valid_i && cmd_ready) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.refused_i) begin
          // Stores complete on acceptance; loads need the data cycle.
          state_nxt = lat_write ? IDLE : WAIT_DATA;
          done_nxt  = lat_write;
        end else begin
          retry_inc = 1'b1;
`ifdef DMEM_RETRY_TIMEOUT_EN
          // The counter still holds the previous refusals, so this refusal
          // is the MAX_RETRY-th one when the count equals MAX_RETRY-1.
          if (retry_cnt == LAST_TRY) state_nxt = ERROR;
`endif
        end
      end
      WAIT_DATA: begin
        capture   = 1'b1;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
`ifdef DMEM_RETRY_TIMEOUT_EN
      ERROR: begin
        set_err   = 1'b1;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      lat_write <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      retry_cnt <= '0;
`ifdef DMEM_RETRY_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      done_q <= done_nxt;
      if (accept) begin
        lat_write <= bus.cmd_write_i;
        addr_q    <= bus.cmd_addr_i;
        din_q     <= bus.cmd_wdata_i;
        retry_cnt <= '0;
      end else if (retry_inc && (retry_cnt != {RETRY_W{1'b1}})) begin
        // Saturates so an endless refusal stream cannot wrap the count.
        retry_cnt <= retry_cnt + 1'b1;
      end
      if (capture) rdata_q <= bus.dout_i;
`ifdef DMEM_RETRY_TIMEOUT_EN
      if (set_err) err_q <= 1'b1;
`endif
    end
  end

  assign bus.cmd_ready_o      = cmd_ready;
  assign bus.done_o           = done_q;
  assign bus.rdata_o          = rdata_q;
  assign bus.read_write_req_o = (state == ISSUE);
  assign bus.write_en_o       = (state == ISSUE) && lat_write;
  assign bus.addr_o           = addr_q;
  assign bus.din_o            = din_q;
`ifdef DMEM_RETRY_TIMEOUT_EN
  assign bus.error_o          = err_q;
`endif

endmodule

// File: doc/dmem_req_ctrl.md
DMEM_REQ_CTRL -- requirements
Module: dmem_req_ctrl

Interface
REQ-001 SHALL provide parameter D_WIDTH, default 16, data width of dmem words.
REQ-002 SHALL provide parameter A_WIDTH, default 8, dmem address width.
REQ-003 SHALL provide parameter MAX_RETRY, default 4, number of refusals tolerated per request (used only when DMEM_RETRY_TIMEOUT_EN is defined).
REQ-004 SHALL provide clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL provide reset_i  input  1  synchronous, active-high reset.
REQ-006 SHALL provide cmd_valid_i  input  1  execution unit presents a memory command.
REQ-007 SHALL provide cmd_write_i  input  1  1 = store, 0 = load.
REQ-008 SHALL provide cmd_addr_i  input  A_WIDTH  command address.
REQ-009 SHALL provide cmd_wdata_i  input  D_WIDTH  store data.
REQ-010 SHALL provide cmd_ready_o  output  1  controller can accept a command this cycle.
REQ-011 SHALL provide done_o  output  1  one-cycle pulse on command completion.
REQ-012 SHALL provide rdata_o  output  D_WIDTH  last load result, held between loads.
REQ-013 SHALL provide read_write_req_o  output  1  request to dmem.
REQ-014 SHALL provide write_en_o  output  1  dmem write enable, qualified by read_write_req_o.
REQ-015 SHALL provide addr_o  output  A_WIDTH  dmem address.
REQ-016 SHALL provide din_o  output  D_WIDTH  dmem write data.
REQ-017 SHALL provide dout_i  input  D_WIDTH  dmem read data.
REQ-018 SHALL provide refused_i  input  1  dmem refusal of the request presented this cycle.

Function
REQ-019 SHALL implement states IDLE, ISSUE, WAIT_DATA (plus ERROR when DMEM_RETRY_TIMEOUT_EN is defined).
REQ-020 SHALL drive cmd_ready_o = 1 only in IDLE; a command is accepted at an edge where cmd_valid_i & cmd_ready_o, with write/addr/wdata latched and IDLE->ISSUE.
REQ-021 SHALL ignore cmd_valid_i while cmd_ready_o = 0; no queueing.
REQ-022 SHALL, in ISSUE, drive read_write_req_o = 1, write_en_o = latched write, addr_o/din_o = latched values, all stable until accepted.
REQ-023 SHALL treat an ISSUE-cycle edge with refused_i = 0 as acceptance: store -> IDLE with done_o high the next cycle; load -> WAIT_DATA.
REQ-024 SHALL, on an ISSUE-cycle edge with refused_i = 1, stay in ISSUE with identical outputs and increment the retry counter.
REQ-025 SHALL, in WAIT_DATA, drive read_write_req_o = 0, capture dout_i into rdata_o at the edge, go to IDLE, and pulse done_o the following cycle.
REQ-026 SHALL give latency from accepting edge to done_o: store 1 cycle, load 2 cycles, plus 1 cycle per refusal.
REQ-027 SHALL accept a new command in the same cycle done_o is high (back-to-back).
REQ-028 SHALL drive read_write_req_o = 0 and write_en_o = 0 in every state other than ISSUE; refused_i is ignored outside ISSUE.
REQ-029 SHALL leave rdata_o unchanged on stores and on aborted loads.
REQ-030 SHALL clear the retry counter on every command acceptance.

Reset
REQ-031 SHALL, on reset_i high at a rising edge, enter IDLE and set done_o=0, rdata_o=0, read_write_req_o=0, write_en_o=0, addr_o=0, din_o=0, retry counter=0.
REQ-032 SHALL force cmd_ready_o = 0 in any cycle where reset_i = 1.
REQ-033 SHALL abandon any in-flight request on reset mid-operation; no done_o is produced for it.

Configuration
REQ-034 SHALL, with DMEM_RETRY_TIMEOUT_EN defined, on the MAX_RETRY-th consecutive refusal, go ISSUE->ERROR, then pulse done_o and set sticky error_o (extra 1-bit output) and return to IDLE; error_o clears only on reset.
REQ-035 SHALL, without DMEM_RETRY_TIMEOUT_EN, omit error_o and ERROR, and retry indefinitely.

Verification
REQ-036 SHALL verify reset: reset_i=1 for 2 cycles -> all outputs 0, cmd_ready_o=0; released -> cmd_ready_o=1.
REQ-037 SHALL verify stores: write 0,1,2 to addresses 0,1,2 back-to-back -> each request shows write_en_o=1, addr_o=n, din_o=n; done_o one cycle after each acceptance.
REQ-038 SHALL verify loads: read addresses 0,1,2 after REQ-037 -> rdata_o = 0,1,2, done_o two cycles after each acceptance.
REQ-039 SHALL verify refusal: store 16'hABCD to address 8'h05 with refused_i=1 for 3 cycles -> request held unchanged for 4 cycles, done_o at cycle 4.
REQ-040 SHALL verify timeout (macro defined, MAX_RETRY=4): load with refused_i stuck 1 -> error_o=1, done_o pulse, rdata_o unchanged; (undefined) request held for 100 cycles.
REQ-041 SHALL verify reset mid-load: reset_i=1 in WAIT_DATA -> IDLE, no done_o, rdata_o=0.
